// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and parameter defaults.
package uart_ctrl_pkg;

    localparam int unsigned DATA_WIDTH_DEF     = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 100000;
    localparam int unsigned TO_W_DEF           = 17;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection; the search starts at rr_ptr and the pointer moves past the winner on accept.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               found
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] cand;

    // Ascending search from rr_ptr, wrapping modulo NUM_REQ (not necessarily a power of two).
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        grant = found ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= IDX_W'((32'(grant_idx) + 32'd1) % NUM_REQ);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART serializer among NUM_REQ byte producers: round-robin accept, one-cycle
// active-low launch strobe, wait for done, with a watchdog that recovers a lost done.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned TO_W           = TO_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [DATA_WIDTH-1:0]           tx_data,
    output logic                            tx_run_n,
    input  logic                            tx_done,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            timeout_err,
    input  logic                            err_clr
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t           state;
    state_t           state_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             found;
    logic             accept;
    logic             timeout_hit;
    logic [TO_W-1:0]  wd_cnt;

    assign accept    = (state == IDLE) && !rst && found;
    assign req_ready = accept ? grant : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .found     (found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Done has priority over the watchdog in the same WAIT cycle.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:   if (accept) state_nxt = LAUNCH;
            LAUNCH: state_nxt = WAIT;
            WAIT: begin
                if (tx_done) begin
                    state_nxt = IDLE;
                end else if (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs derive from the next state so the strobe lines up with LAUNCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data     <= '0;
            tx_run_n    <= 1'b1;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            tx_run_n <= (state_nxt != LAUNCH);
            busy     <= (state_nxt != IDLE);
            if (accept) begin
                tx_data  <= req_data[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                grant_id <= grant_idx;
            end
            if (state == LAUNCH) begin
                wd_cnt <= '0;
            end else if (state == WAIT && wd_cnt != {TO_W{1'b1}}) begin
                wd_cnt <= wd_cnt + TO_W'(1);
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic against a frame-level model,
// with a serializer model driving tx_done and a second instance for the short watchdog.
module tb_uart_tx_arbiter;

    localparam int NR   = 4;
    localparam int CPB  = 16;
    localparam int T_M  = 200;
    localparam int T_TO = 50;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*8-1:0]  req_data;
    logic             err_clr;
    logic             tx_done;
    logic             uart_done;
    logic             man_done;
    logic             uart_en;

    logic [NR-1:0]    req_ready;
    logic [7:0]       tx_data;
    logic             tx_run_n;
    logic             busy;
    logic [1:0]       grant_id;
    logic             timeout_err;

    logic [NR-1:0]    to_ready;
    logic [7:0]       to_data;
    logic             to_run_n;
    logic             to_busy;
    logic [1:0]       to_gid;
    logic             to_err;
    logic             to_done;

    int n_err    = 0;
    int n_checks = 0;

    assign tx_done = uart_done | man_done;
    assign to_done = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(8), .TIMEOUT_CYCLES(T_M), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_data(tx_data), .tx_run_n(tx_run_n), .tx_done(tx_done),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(8), .TIMEOUT_CYCLES(T_TO), .TO_W(6)) dut_to (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(to_ready), .tx_data(to_data), .tx_run_n(to_run_n), .tx_done(to_done),
        .busy(to_busy), .grant_id(to_gid), .timeout_err(to_err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serializer model: 8N1 frame at CPB clocks per bit, data bits read live from tx_data.
    logic       u_active;
    int         u_cnt;
    logic [7:0] rx_byte;
    logic       line;
    int         bitn;

    always_comb begin
        bitn = u_cnt / CPB;
        if (!u_active)      line = 1'b1;
        else if (bitn == 0) line = 1'b0;
        else if (bitn >= 9) line = 1'b1;
        else                line = tx_data[bitn-1];
    end

    always @(posedge clk) begin
        if (rst || !uart_en) begin
            u_active  <= 1'b0;
            u_cnt     <= 0;
            uart_done <= 1'b0;
        end else begin
            uart_done <= 1'b0;
            if (!u_active && !tx_run_n) begin
                u_active <= 1'b1;
                u_cnt    <= 0;
                rx_byte  <= 8'h00;
            end else if (u_active) begin
                u_cnt <= u_cnt + 1;
                if ((u_cnt % CPB) == CPB/2 && bitn >= 1 && bitn <= 8) rx_byte[bitn-1] <= line;
                if (u_cnt == 10*CPB - 1) begin
                    u_active  <= 1'b0;
                    uart_done <= 1'b1;
                end
            end
        end
    end

    // Frame-level reference: age 1 is the strobe cycle, age >= 2 waits for done or the deadline.
    bit         m_known, m_in_frame, m_err;
    int         m_ptr, m_age, m_gid;
    logic [7:0] m_data;
    int         obs_q[$];
    int         run_low_cnt;

    function automatic int winner(input logic [NR-1:0] v, input int ptr);
        for (int i = 0; i < NR; i++) begin
            if (v[(ptr + i) % NR]) return (ptr + i) % NR;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_check();
        int w;
        logic [NR-1:0] exp_rdy;
        exp_rdy = '0;
        w = winner(req_valid, m_ptr);
        if (!rst && m_known && !m_in_frame && w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (m_known) begin
            chk("busy", 32'(busy), 32'(m_in_frame));
            chk("tx_run_n", 32'(tx_run_n), 32'(!(m_in_frame && m_age == 1)));
            chk("tx_data", 32'(tx_data), 32'(m_data));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("timeout_err", 32'(timeout_err), 32'(m_err));
        end
    endtask

    task automatic model_update();
        int w;
        bit set_err;
        set_err = 1'b0;
        if (rst) begin
            m_known = 1'b1; m_in_frame = 1'b0; m_ptr = 0; m_age = 0;
            m_gid = 0; m_data = 8'h00; m_err = 1'b0;
            return;
        end
        if (!m_in_frame) begin
            w = winner(req_valid, m_ptr);
            if (w >= 0) begin
                m_in_frame = 1'b1; m_age = 1; m_gid = w;
                m_data = req_data[w*8 +: 8];
                m_ptr = (w + 1) % NR;
            end
        end else if (m_age >= 2 && tx_done) begin
            if (uart_done) chk("rx_byte", 32'(rx_byte), 32'(m_data));
            m_in_frame = 1'b0;
        end else if (m_age == T_M + 1) begin
            m_in_frame = 1'b0;
            set_err = 1'b1;
        end else begin
            m_age++;
        end
        if (set_err) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        if (req_ready != '0) obs_q.push_back(onehot_idx(req_ready));
        if (!tx_run_n) run_low_cnt++;
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (m_in_frame && n < budget) begin cyc(); n++; end
        chk("idle_wait", 32'(m_in_frame), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    endtask

    initial begin
        int n;
        int exp_f[5];
        exp_f = '{0, 1, 2, 3, 0};
        rst = 1'b1; req_valid = '0; req_data = '0; err_clr = 1'b0;
        man_done = 1'b0; uart_en = 1'b1;
        m_known = 1'b0; m_in_frame = 1'b0; m_err = 1'b0;
        m_ptr = 0; m_age = 0; m_gid = 0; m_data = 8'h00; run_low_cnt = 0;
        do_reset();

        // Single request
        obs_q.delete(); run_low_cnt = 0;
        req_data[7:0] = 8'hA5; req_valid = 4'b0001; cyc(); req_valid = '0;
        run_until_idle(400);
        cyc();
        chk("single_grants", 32'(obs_q.size()), 32'd1);
        chk("single_run_low", 32'(run_low_cnt), 32'd1);
        chk("single_data", 32'(tx_data), 32'hA5);

        // Fairness
        do_reset(); obs_q.delete();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11}; req_valid = 4'b1111;
        n = 0;
        while (obs_q.size() < 5 && n < 2000) begin cyc(); n++; end
        req_valid = '0;
        run_until_idle(400);
        chk("fair_count", 32'(obs_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs_q.size(); i++) chk("fair_order", 32'(obs_q[i]), 32'(exp_f[i]));

        // Wrap/skip from pointer 3
        do_reset();
        req_valid = 4'b0001; cyc(); req_valid = '0; run_until_idle(400);
        req_valid = 4'b0100; cyc(); req_valid = '0; run_until_idle(400);
        obs_q.delete(); req_valid = 4'b0101; n = 0;
        while (obs_q.size() < 2 && n < 1000) begin cyc(); n++; end
        req_valid = '0; run_until_idle(400);
        req_valid = 4'b1111; cyc(); req_valid = '0; run_until_idle(400);
        chk("wrap_count", 32'(obs_q.size()), 32'd3);
        if (obs_q.size() == 3) begin
            chk("wrap_first", 32'(obs_q[0]), 32'd0);
            chk("wrap_second", 32'(obs_q[1]), 32'd2);
            chk("wrap_ptr3", 32'(obs_q[2]), 32'd3);
        end

        // Reset mid-frame
        req_valid = 4'b0001; cyc(); req_valid = '0;
        repeat (5) cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_run_n", 32'(tx_run_n), 32'd1);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        obs_q.delete();
        req_valid = 4'b0100; cyc(); req_valid = '0; run_until_idle(400);
        chk("rst_accept2", 32'(obs_q.size() == 1 ? obs_q[0] : -1), 32'd2);

        // Done ignored in IDLE and LAUNCH; then done/timeout collision
        uart_en = 1'b0;
        man_done = 1'b1; cyc(); man_done = 1'b0; cyc();
        chk("idle_done_busy", 32'(busy), 32'd0);
        req_valid = 4'b0010; cyc(); req_valid = '0;
        man_done = 1'b1; cyc(); man_done = 1'b0; cyc();
        chk("launch_done_busy", 32'(busy), 32'd1);
        run_until_idle(400);
        chk("timeout_main", 32'(timeout_err), 32'd1);
        err_clr = 1'b1; cyc(); err_clr = 1'b0; cyc();
        chk("err_clr", 32'(timeout_err), 32'd0);
        req_valid = 4'b0001; cyc(); req_valid = '0;
        n = 0;
        while (!(m_in_frame && m_age == T_M + 1) && n < 400) begin cyc(); n++; end
        man_done = 1'b1; cyc(); man_done = 1'b0; cyc();
        chk("collide_err", 32'(timeout_err), 32'd0);
        chk("collide_busy", 32'(busy), 32'd0);
        uart_en = 1'b1;

        // Watchdog at 50 cycles on the second instance
        do_reset();
        req_valid = 4'b0010; n = 0;
        while (to_run_n !== 1'b0 && n < 10) begin cyc(); n++; end
        chk("to_launch", 32'(to_run_n), 32'd0);
        for (int k = 1; k <= T_TO; k++) begin
            cyc();
            chk("to_pre_err", 32'(to_err), 32'd0);
        end
        cyc();
        chk("to_err_set", 32'(to_err), 32'd1);
        chk("to_idle", 32'(to_busy), 32'd0);
        chk("to_pending", 32'(to_ready), 32'b0010);
        req_valid = '0; err_clr = 1'b1; cyc(); err_clr = 1'b0;
        chk("to_err_clr", 32'(to_err), 32'd0);
        run_until_idle(400);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                req_valid = NR'($urandom_range(0, 15));
                req_data  = $urandom();
            end
            err_clr = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 699) == 0);
            cyc();
        end
        rst = 1'b0; err_clr = 1'b0; req_valid = '0;
        run_until_idle(400);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
